// File: rtl/sr_req_arbiter.sv
// Round-robin arbiter granting NREQ requesters set/clear access to a shared SR flop bank.
// Each grant drives one s_out/r_out bit for PULSE cycles, then acks and updates q_mirror.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for any req; picks a round-robin winner and latches it
// ST_DRIVE | one s_out or r_out bit held high; down-counter times the pulse
// ST_ACK   | ack[winner] (and err for illegal cmd) high; pointer advances
module sr_req_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 3,
    parameter int PULSE  = 2,
    localparam int NBITS = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        cmd,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    output logic [NBITS-1:0]         s_out,
    output logic [NBITS-1:0]         r_out,
    output logic [NBITS-1:0]         q_mirror,
    output logic                     busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_CLR = 2'b01;
    localparam logic [1:0] CMD_SET = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    if (PULSE < 1 || PULSE > 15) begin : g_bad_pulse
        $error("sr_req_arbiter: PULSE must be within 1..15");
    end

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                err_q, err_d;
    logic [NBITS-1:0]    s_q, s_d;
    logic [NBITS-1:0]    r_q, r_d;
    logic [NBITS-1:0]    qm_q, qm_d;
    logic                busy_q, busy_d;

    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [1:0]          pick_cmd;
    logic [ADDR_W-1:0]   pick_addr;
    logic [NBITS-1:0]    pick_bit;
    logic [NBITS-1:0]    held_bit;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NREQ) sum = sum - NREQ;
        return PTR_W'(sum);
    endfunction

    // First requester at or after ptr_q, wrapping, wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_valid && req[rr_idx(ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        pick_cmd  = cmd[2*int'(pick_idx) +: 2];
        pick_addr = addr[ADDR_W*int'(pick_idx) +: ADDR_W];
        pick_bit  = NBITS'(1) << pick_addr;
        held_bit  = NBITS'(1) << addr_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        s_d     = s_q;
        r_d     = r_q;
        qm_d    = qm_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_d  = pick_idx;
                    cmd_d  = pick_cmd;
                    addr_d = pick_addr;
                    busy_d = 1'b1;
                    case (pick_cmd)
                        CMD_SET: begin
                            state_d = ST_DRIVE;
                            s_d     = pick_bit;
                            cnt_d   = 4'(PULSE - 1);
                        end
                        CMD_CLR: begin
                            state_d = ST_DRIVE;
                            r_d     = pick_bit;
                            cnt_d   = 4'(PULSE - 1);
                        end
                        CMD_NOP, CMD_ILL: begin
                            // No bank activity: straight to completion.
                            state_d         = ST_ACK;
                            ack_d[pick_idx] = 1'b1;
                            err_d           = (pick_cmd == CMD_ILL);
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_ACK;
                    s_d          = '0;
                    r_d          = '0;
                    ack_d[win_q] = 1'b1;
                    if (cmd_q == CMD_SET) qm_d = qm_q | held_bit;
                    else                  qm_d = qm_q & ~held_bit;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (int'(win_q) == NREQ - 1) ptr_d = '0;
                else                         ptr_d = win_q + 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
            qm_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            s_q     <= s_d;
            r_q     <= r_d;
            qm_q    <= qm_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign s_out    = s_q;
    assign r_out    = r_q;
    assign q_mirror = qm_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sr_req_arbiter.sv
// Bench for sr_req_arbiter: directed per-cycle vector table, hand sequences for
// reset/req-drop/contention, then random traffic against a transaction-schedule model.
module tb_sr_req_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 3;
    localparam int PULSE  = 2;
    localparam int NBITS  = 8;

    logic              clk;
    logic              rst_n;
    logic [3:0]        req;
    logic [7:0]        cmd;
    logic [11:0]       addr;
    logic [3:0]        ack;
    logic              err;
    logic [7:0]        s_out;
    logic [7:0]        r_out;
    logic [7:0]        q_mirror;
    logic              busy;

    sr_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .PULSE(PULSE)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .req      (req),
        .cmd      (cmd),
        .addr     (addr),
        .ack      (ack),
        .err      (err),
        .s_out    (s_out),
        .r_out    (r_out),
        .q_mirror (q_mirror),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ack;
        logic       err;
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] qm;
        logic       busy;
    } out_t;

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  req;
        logic [7:0]  cmd;
        logic [11:0] addr;
        out_t        exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: on each accepted request, the whole future of the outputs is queued.
    out_t       sched[$];
    int         m_ptr = 0;
    logic [7:0] m_qm  = 8'h00;

    bit         logging = 0;
    int         ack_log[$];
    logic [7:0] s_log[$];

    function automatic out_t sample_dut();
        out_t o;
        o = {ack, err, s_out, r_out, q_mirror, busy};
        return o;
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got ack=%h err=%b s=%h r=%h qm=%h busy=%b, want ack=%h err=%b s=%h r=%h qm=%h busy=%b",
                     name, got.ack, got.err, got.s, got.r, got.qm, got.busy,
                     exp.ack, exp.err, exp.s, exp.r, exp.qm, exp.busy);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic model_accept();
        int w;
        logic [1:0] c;
        int a;
        logic [7:0] bitv;
        out_t e;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        c = cmd[2*w +: 2];
        a = int'(addr[ADDR_W*w +: ADDR_W]);
        bitv = 8'h01 << a;
        m_ptr = (w + 1) % NREQ;
        if (c == 2'b10 || c == 2'b01) begin
            for (int p = 0; p < PULSE; p++) begin
                e = '0;
                if (c == 2'b10) e.s = bitv; else e.r = bitv;
                e.qm = m_qm;
                e.busy = 1'b1;
                sched.push_back(e);
            end
            if (c == 2'b10) m_qm = m_qm | bitv; else m_qm = m_qm & ~bitv;
            e = '0;
        end else begin
            e = '0;
            e.err = (c == 2'b11);
        end
        e.ack = 4'b0001 << w;
        e.qm = m_qm;
        e.busy = 1'b1;
        sched.push_back(e);
        e = '0;
        e.qm = m_qm;
        sched.push_back(e);
    endtask

    // Uses the inputs currently applied, advances one edge, compares #1 after it.
    task automatic tick(input string name);
        out_t exp;
        out_t got;
        if (!rst_n) begin
            sched.delete();
            m_ptr = 0;
            m_qm = 8'h00;
            exp = '0;
        end else begin
            if (sched.size() == 0 && req != 4'h0) model_accept();
            if (sched.size() > 0) begin
                exp = sched.pop_front();
            end else begin
                exp = '0;
                exp.qm = m_qm;
            end
        end
        @(posedge clk);
        #1;
        got = sample_dut();
        check_out(name, got, exp);
        total++;
        if (((s_out & r_out) != 8'h00) || ($countones(s_out | r_out) > 1)) begin
            bad++;
            $display("FAIL %s_onehot: got s=%h r=%h, want at most one bit high", name, s_out, r_out);
        end
        if (logging) begin
            for (int j = 0; j < NREQ; j++) if (ack[j]) ack_log.push_back(j);
            if (s_out != 8'h00 && (s_log.size() == 0 || s_log[$] != s_out)) s_log.push_back(s_out);
        end
    endtask

    vec_t vec[18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        //            rst   req    cmd    addr     ack   err   s      r      qm     busy
        vec[0]  = '{1'b0, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}};
        vec[1]  = '{1'b1, 4'h1, 8'h02, 12'h005, '{4'h0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1}};
        vec[2]  = '{1'b1, 4'h0, 8'h02, 12'h005, '{4'h0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1}};
        vec[3]  = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h1, 1'b0, 8'h00, 8'h00, 8'h20, 1'b1}};
        vec[4]  = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h20, 1'b0}};
        vec[5]  = '{1'b1, 4'h4, 8'h30, 12'h000, '{4'h4, 1'b1, 8'h00, 8'h00, 8'h20, 1'b1}};
        vec[6]  = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h20, 1'b0}};
        vec[7]  = '{1'b1, 4'h4, 8'h00, 12'h000, '{4'h4, 1'b0, 8'h00, 8'h00, 8'h20, 1'b1}};
        vec[8]  = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h20, 1'b0}};
        vec[9]  = '{1'b0, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}};
        vec[10] = '{1'b1, 4'h2, 8'h08, 12'h018, '{4'h0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1}};
        vec[11] = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1}};
        vec[12] = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h2, 1'b0, 8'h00, 8'h00, 8'h08, 1'b1}};
        vec[13] = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h08, 1'b0}};
        vec[14] = '{1'b1, 4'h4, 8'h10, 12'h0C0, '{4'h0, 1'b0, 8'h00, 8'h08, 8'h08, 1'b1}};
        vec[15] = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h08, 8'h08, 1'b1}};
        vec[16] = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h4, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1}};
        vec[17] = '{1'b1, 4'h0, 8'h00, 12'h000, '{4'h0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}};

        rst_n = 1'b0;
        req   = 4'h0;
        cmd   = 8'h00;
        addr  = 12'h000;

        for (int i = 0; i < 18; i++) begin
            rst_n = vec[i].rst_n;
            req   = vec[i].req;
            cmd   = vec[i].cmd;
            addr  = vec[i].addr;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), sample_dut(), vec[i].exp);
        end

        // Reset during the first drive cycle of a set.
        rst_n = 1'b0; req = 4'h0; tick("mid_rst_pre");
        rst_n = 1'b1; req = 4'h1; cmd = 8'h02; addr = 12'h005; tick("mid_rst_drive");
        rst_n = 1'b0; req = 4'h0; tick("mid_rst_hit");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick($sformatf("mid_rst_after%0d", i));

        // Requester drops req right after being sampled; clear of bit 7 still completes.
        req = 4'h1; cmd = 8'h01; addr = 12'h007; tick("drop_sample");
        req = 4'h0;
        for (int i = 0; i < 4; i++) tick($sformatf("drop%0d", i));

        // Full contention from reset: strict rotation 0,1,2,3,0.
        rst_n = 1'b0; tick("cont_rst");
        rst_n = 1'b1; req = 4'hF; cmd = 8'hAA; addr = {3'd3, 3'd2, 3'd1, 3'd0};
        ack_log.delete(); s_log.delete(); logging = 1;
        for (int i = 0; i < 20; i++) tick($sformatf("cont%0d", i));
        logging = 0;
        check_int("cont_ack_count", (ack_log.size() >= 5) ? 1 : 0, 1);
        if (ack_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_int($sformatf("cont_ack_order%0d", i), ack_log[i], i % NREQ);
        end
        check_int("cont_s_count", (s_log.size() >= 4) ? 1 : 0, 1);
        if (s_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check_int($sformatf("cont_s_seq%0d", i), int'(s_log[i]), 1 << i);
        end

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            req   = 4'($urandom_range(0, 15));
            cmd   = 8'($urandom);
            addr  = 12'($urandom);
            tick($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_req_arbiter.md
SR_REQ_ARBITER -- requirements
Module: sr_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the SR flop bank.
REQ-002 Parameter ADDR_W, default 3, bit-select width; bank size NBITS = 2**ADDR_W (8).
REQ-003 Parameter PULSE, default 2, cycles s_out/r_out are held per operation (legal range 1..15).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-006 req  input  NREQ  per-requester request level.
REQ-007 cmd  input  2*NREQ  per-requester command, slice i = cmd[2i+1:2i]: 00 nop, 01 clear, 10 set, 11 illegal.
REQ-008 addr  input  NREQ*ADDR_W  per-requester target bit index, slice i = addr[ADDR_W*i +: ADDR_W].
REQ-009 ack  output  NREQ  one-cycle completion pulse to the served requester.
REQ-010 err  output  1  one-cycle pulse, coincident with ack, for an illegal command.
REQ-011 s_out  output  NBITS  set drive to flop bank.
REQ-012 r_out  output  NBITS  clear drive to flop bank.
REQ-013 q_mirror  output  NBITS  arbiter's copy of bank state after each completed operation.
REQ-014 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, ACK; all outputs registered.
REQ-016 In IDLE with any req high, the arbiter SHALL pick a winner round-robin starting at pointer ptr, latch winner index, cmd and addr, and leave IDLE on the next edge.
REQ-017 Latched cmd 01/10 SHALL go IDLE->DRIVE; cmd 00/11 SHALL go IDLE->ACK directly.
REQ-018 In DRIVE, exactly one bit of s_out (set) or r_out (clear), at latched addr, SHALL be high for exactly PULSE consecutive cycles, then DRIVE->ACK.
REQ-019 s_out and r_out SHALL never be high on the same bit, and never more than one bit high in total, in any cycle.
REQ-020 In ACK, ack[winner] SHALL be high for one cycle; q_mirror[addr] SHALL update (1 for set, 0 for clear) in that cycle; ptr SHALL become (winner+1) mod NREQ; ACK->IDLE unconditionally.
REQ-021 err SHALL be high in the ACK cycle only for latched cmd 11; nop and illegal leave s_out, r_out, q_mirror unchanged.
REQ-022 Latency for set/clear: req sampled in IDLE at edge t -> drive cycles t+1..t+PULSE -> ack at t+PULSE+1; for nop/illegal ack at t+1.
REQ-023 req, cmd, addr SHALL be ignored outside IDLE; deassertion of req mid-operation SHALL NOT abort the latched operation.
REQ-024 A requester holding req high after its ack SHALL be re-served only after every other pending requester has been served once (no starvation).
REQ-025 With NREQ requesters continuously requesting, grants SHALL follow order ptr, ptr+1, ..., wrapping NREQ-1 -> 0.
REQ-026 busy SHALL be high in DRIVE and ACK, low in IDLE.

Reset
REQ-027 reset low at a rising edge SHALL force, on that edge, state IDLE, ptr 0, ack 0, err 0, s_out 0, r_out 0, q_mirror 0, busy 0, regardless of state (including mid-DRIVE).
REQ-028 An operation interrupted by reset SHALL NOT produce ack and SHALL NOT update q_mirror; first evaluation of req occurs at the first edge with reset high.

Verification
REQ-029 Single set: req=0001, cmd0=10, addr0=5, PULSE=2 -> s_out=0x20 for 2 cycles, ack=0001 on next cycle, q_mirror=0x20, err=0.
REQ-030 Contention: req=1111 held, all cmd=10, addr_i=i, from reset -> acks in order 0,1,2,3,0; s_out sequence 0x01,0x02,0x04,0x08; no cycle with two bits high.
REQ-031 Illegal and nop: req=0100, cmd2=11 -> ack=0100 and err=1 one cycle after sampling, s_out=r_out=0; cmd2=00 -> ack only, err=0.
REQ-032 Clear after set: set bit 3 from requester 1, then clear bit 3 from requester 2 -> r_out=0x08 for PULSE cycles, q_mirror 0x08 -> 0x00 at requester 2 ack.
REQ-033 Reset mid-DRIVE: set in progress, reset low one edge during first drive cycle -> s_out=0, busy=0, no ack, q_mirror=0x00 after that edge.
REQ-034 Req drop: req0 deasserted the cycle after sampling with cmd 01, addr 7 -> r_out=0x80 still driven PULSE cycles and ack=0001 still issued.
